// File: rtl/dbus_pkg.sv
// Shared types and constants for the two-master data-bus arbiter.
// Imported by dbus_arbiter; holds owner states, master ids and the burst-count width.
package dbus_pkg;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    typedef enum logic {
        MST0 = 1'b0,
        MST1 = 1'b1
    } master_t;

    function automatic state_t own_state(master_t m);
        return (m == MST1) ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/dbus_master_mux.sv
// Combinational request/data multiplexer: steers the granted master's
// address, write data and byte enables onto the shared data port.
module dbus_master_mux (
    input  logic        gnt,
    input  logic        sel,
    input  logic [15:0] m0_addr,
    input  logic [1:0]  m0_we,
    input  logic [15:0] m0_wdata,
    input  logic [15:0] m1_addr,
    input  logic [1:0]  m1_we,
    input  logic [15:0] m1_wdata,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    output logic [1:0]  bus_we
);

    // Without a grant the shared port is parked at zero so no stray write fires.
    always_comb begin
        bus_addr  = 16'h0000;
        bus_wdata = 16'h0000;
        bus_we    = 2'b00;
        if (gnt) begin
            if (sel) begin
                bus_addr  = m1_addr;
                bus_wdata = m1_wdata;
                bus_we    = m1_we;
            end else begin
                bus_addr  = m0_addr;
                bus_wdata = m0_wdata;
                bus_we    = m0_we;
            end
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master (CPU/DMA) data-bus arbiter with bounded bursts and a one-deep
// read tag that routes the slave's next-cycle read data back to its issuer.
module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter int MAXBURST = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_req,
    input  logic [15:0] m0_addr,
    input  logic [1:0]  m0_we,
    input  logic [15:0] m0_wdata,
    input  logic        m1_req,
    input  logic [15:0] m1_addr,
    input  logic [1:0]  m1_we,
    input  logic [15:0] m1_wdata,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_rvalid,
    output logic        m1_rvalid,
    output logic [15:0] rdata,
    output logic [15:0] dread_addr,
    output logic [15:0] dwrite_addr,
    output logic [15:0] dwrite_data,
    output logic [1:0]  dwrite_en,
    input  logic [15:0] dread_data
);

    localparam logic [CNT_W-1:0] MAXB = CNT_W'(MAXBURST);

    state_t           state_q, state_d;
    master_t          last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tag_valid_q, tag_valid_d;
    master_t          tag_master_q, tag_master_d;

    logic             gnt_any;
    master_t          winner;
    logic [15:0]      bus_addr;

    // Grants are gated by reset_n so nothing is accepted while reset is held.
    always_comb begin
        gnt_any = 1'b0;
        winner  = MST0;
        if (reset_n) begin
            if (m0_req && m1_req) begin
                gnt_any = 1'b1;
                if (state_q == OWN0 && cnt_q < MAXB) begin
                    winner = MST0;
                end else if (state_q == OWN1 && cnt_q < MAXB) begin
                    winner = MST1;
                end else begin
                    winner = (last_q == MST0) ? MST1 : MST0;
                end
            end else if (m0_req) begin
                gnt_any = 1'b1;
                winner  = MST0;
            end else if (m1_req) begin
                gnt_any = 1'b1;
                winner  = MST1;
            end
        end
    end

    dbus_master_mux u_mux (
        .gnt       (gnt_any),
        .sel       (winner == MST1),
        .m0_addr   (m0_addr),
        .m0_we     (m0_we),
        .m0_wdata  (m0_wdata),
        .m1_addr   (m1_addr),
        .m1_we     (m1_we),
        .m1_wdata  (m1_wdata),
        .bus_addr  (bus_addr),
        .bus_wdata (dwrite_data),
        .bus_we    (dwrite_en)
    );

    // The last winner deliberately survives idle cycles so ties keep alternating.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        tag_valid_d  = 1'b0;
        tag_master_d = tag_master_q;
        if (gnt_any) begin
            state_d      = own_state(winner);
            last_d       = winner;
            tag_valid_d  = (dwrite_en == 2'b00);
            tag_master_d = winner;
            if (state_q == own_state(winner)) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end else begin
                cnt_d = CNT_W'(1);
            end
        end else begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_q       <= MST1;
            cnt_q        <= '0;
            tag_valid_q  <= 1'b0;
            tag_master_q <= MST0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            tag_valid_q  <= tag_valid_d;
            tag_master_q <= tag_master_d;
        end
    end

    assign m0_gnt      = gnt_any && (winner == MST0);
    assign m1_gnt      = gnt_any && (winner == MST1);
    assign m0_rvalid   = tag_valid_q && (tag_master_q == MST0);
    assign m1_rvalid   = tag_valid_q && (tag_master_q == MST1);
    assign rdata       = dread_data;
    assign dread_addr  = bus_addr;
    assign dwrite_addr = bus_addr;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Self-checking bench for dbus_arbiter: directed scenarios plus random traffic
// against a small arbitration model, with a queue of expected read returns.
module tb_dbus_arbiter;

    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_req, m1_req;
    logic [15:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [1:0]  m0_we, m1_we;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [15:0] rdata, dread_addr, dwrite_addr, dwrite_data, dread_data;
    logic [1:0]  dwrite_en;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        master;
        logic [15:0] data;
    } rd_t;

    rd_t rd_q[$];
    int  gnt_q[$];

    int  st, last_w, cnt;

    dbus_arbiter #(.MAXBURST(MB)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .m0_req      (m0_req),
        .m0_addr     (m0_addr),
        .m0_we       (m0_we),
        .m0_wdata    (m0_wdata),
        .m1_req      (m1_req),
        .m1_addr     (m1_addr),
        .m1_we       (m1_we),
        .m1_wdata    (m1_wdata),
        .m0_gnt      (m0_gnt),
        .m1_gnt      (m1_gnt),
        .m0_rvalid   (m0_rvalid),
        .m1_rvalid   (m1_rvalid),
        .rdata       (rdata),
        .dread_addr  (dread_addr),
        .dwrite_addr (dwrite_addr),
        .dwrite_data (dwrite_data),
        .dwrite_en   (dwrite_en),
        .dread_data  (dread_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Arbitration model: returns -1 for no grant, else the winning master.
    function automatic int predict(logic r0, logic r1);
        if (r0 && r1) begin
            if (st == 1 && cnt < MB) return 0;
            if (st == 2 && cnt < MB) return 1;
            return 1 - last_w;
        end
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic model_update(input int w);
        if (w < 0) begin
            st  = 0;
            cnt = 0;
        end else begin
            if (st == w + 1) cnt = (cnt == 15) ? 15 : cnt + 1;
            else cnt = 1;
            st     = w + 1;
            last_w = w;
        end
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m1_req = 1'b0;
        m0_addr = 16'h0; m1_addr = 16'h0;
        m0_wdata = 16'h0; m1_wdata = 16'h0;
        m0_we = 2'b00; m1_we = 2'b00;
        dread_data = 16'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        st = 0; last_w = 1; cnt = 0;
        rd_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1;
        m0_we = 2'b11; m1_we = 2'b01;
        m0_addr = 16'h1234; m1_addr = 16'h5678;
        #1;
        vectors++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, dwrite_en} !== 6'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_hold: got gnt/rv/en %b expected %b",
                     {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, dwrite_en}, 6'b0);
        end
        vectors++;
        if (dwrite_addr !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_addr: got %h expected 0000", dwrite_addr);
        end
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b1;
        #1;
        vectors++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, dwrite_en, dwrite_addr, dwrite_data} !== 38'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_release: got %h expected 0",
                     {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, dwrite_en, dwrite_addr, dwrite_data});
        end
    endtask

    task automatic test_write();
        do_reset();
        @(negedge clk);
        m0_req = 1'b1; m0_addr = 16'h2004; m0_wdata = 16'hBEEF; m0_we = 2'b11;
        #1;
        vectors++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL write_gnt: got %b expected 10", {m0_gnt, m1_gnt});
        end
        vectors++;
        if ({dwrite_addr, dwrite_data, dwrite_en} !== {16'h2004, 16'hBEEF, 2'b11}) begin
            miscompares++;
            $display("[TB] FAIL write_bus: got %h/%h/%b expected 2004/beef/11",
                     dwrite_addr, dwrite_data, dwrite_en);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        vectors++;
        if ({m0_rvalid, m1_rvalid, dwrite_en} !== 4'b0) begin
            miscompares++;
            $display("[TB] FAIL write_no_rvalid: got %b expected 0000",
                     {m0_rvalid, m1_rvalid, dwrite_en});
        end
    endtask

    task automatic test_burst();
        int exp_w;
        logic [1:0] exp_g;
        do_reset();
        foreach (gnt_q[i]) gnt_q.delete();
        gnt_q = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            m0_req = 1'b1; m1_req = 1'b1;
            m0_we = 2'b01; m1_we = 2'b10;
            m0_addr = 16'h0100 + 16'(c); m1_addr = 16'h0200 + 16'(c);
            #1;
            exp_w = gnt_q.pop_front();
            exp_g = (exp_w == 0) ? 2'b10 : 2'b01;
            vectors++;
            if ({m0_gnt, m1_gnt} !== exp_g) begin
                miscompares++;
                $display("[TB] FAIL burst_c%0d: got %b expected %b", c, {m0_gnt, m1_gnt}, exp_g);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        rd_t e;
        logic [1:0] exp_rv;
        logic [15:0] exp_rd;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            idle_inputs();
            if (c == 0) begin
                m1_req = 1'b1; m1_addr = 16'h0010;
            end else if (c == 1) begin
                m0_req = 1'b1; m0_addr = 16'h2000;
            end
            exp_rv = 2'b00;
            exp_rd = 16'h0;
            if (rd_q.size() > 0) begin
                e = rd_q.pop_front();
                dread_data = e.data;
                exp_rv = e.master ? 2'b01 : 2'b10;
                exp_rd = e.data;
            end
            #1;
            vectors++;
            if ({m0_rvalid, m1_rvalid} !== exp_rv || rdata !== exp_rd) begin
                miscompares++;
                $display("[TB] FAIL b2b_rvalid_c%0d: got rv %b rdata %h expected rv %b rdata %h",
                         c, {m0_rvalid, m1_rvalid}, rdata, exp_rv, exp_rd);
            end
            if (c == 0) begin
                vectors++;
                if ({m1_gnt, dread_addr} !== {1'b1, 16'h0010}) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_m1_gnt: got %b/%h expected 1/0010", m1_gnt, dread_addr);
                end
                rd_q.push_back('{master: 1'b1, data: 16'h1111});
            end else if (c == 1) begin
                vectors++;
                if ({m0_gnt, dread_addr} !== {1'b1, 16'h2000}) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_m0_gnt: got %b/%h expected 1/2000", m0_gnt, dread_addr);
                end
                rd_q.push_back('{master: 1'b0, data: 16'h2222});
            end
        end
    endtask

    task automatic test_idle_tie();
        do_reset();
        @(negedge clk);
        m1_req = 1'b1; m1_we = 2'b11;
        #1;
        vectors++;
        if ({m0_gnt, m1_gnt} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL tie_m1_alone: got %b expected 01", {m0_gnt, m1_gnt});
        end
        @(negedge clk);
        idle_inputs();
        #1;
        vectors++;
        if ({m0_gnt, m1_gnt, dwrite_en} !== 4'b0) begin
            miscompares++;
            $display("[TB] FAIL tie_idle: got %b expected 0000", {m0_gnt, m1_gnt, dwrite_en});
        end
        @(negedge clk);
        m0_req = 1'b1; m1_req = 1'b1; m0_we = 2'b11; m1_we = 2'b11;
        #1;
        vectors++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL tie_m0_wins: got %b expected 10", {m0_gnt, m1_gnt});
        end
        @(negedge clk);
        vectors++;
        if (dut.cnt_q !== 4'd1) begin
            miscompares++;
            $display("[TB] FAIL tie_count: got %0d expected 1", dut.cnt_q);
        end
        idle_inputs();
        do_reset();
        @(negedge clk);
        m0_req = 1'b1; m0_we = 2'b01;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        m0_req = 1'b1; m1_req = 1'b1; m0_we = 2'b01; m1_we = 2'b01;
        #1;
        vectors++;
        if ({m0_gnt, m1_gnt} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL tie_last_kept: got %b expected 01", {m0_gnt, m1_gnt});
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_inflight();
        do_reset();
        @(negedge clk);
        m0_req = 1'b1; m0_addr = 16'h3000; m0_we = 2'b00;
        #1;
        vectors++;
        if (m0_gnt !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL inflight_gnt: got %b expected 1", m0_gnt);
        end
        @(negedge clk);
        reset_n = 1'b0;
        m1_req = 1'b1; m1_we = 2'b11;
        dread_data = 16'hABCD;
        #1;
        vectors++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, dwrite_en, dwrite_addr} !== 22'b0) begin
            miscompares++;
            $display("[TB] FAIL inflight_in_reset: got %h expected 0",
                     {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, dwrite_en, dwrite_addr});
        end
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b1;
        #1;
        vectors++;
        if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL inflight_after: got %b expected 00", {m0_rvalid, m1_rvalid});
        end
        st = 0; last_w = 1; cnt = 0;
        rd_q.delete();
    endtask

    task automatic test_random();
        rd_t         e;
        int          w;
        logic [69:0] exp_v, got_v;
        logic        erv0, erv1;
        logic [1:0]  ewe;
        logic [15:0] ead, ewd;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            m0_req   = 1'($urandom_range(0, 1));
            m1_req   = 1'($urandom_range(0, 1));
            m0_we    = 2'($urandom_range(0, 3));
            m1_we    = 2'($urandom_range(0, 3));
            m0_addr  = 16'($urandom);
            m1_addr  = 16'($urandom);
            m0_wdata = 16'($urandom);
            m1_wdata = 16'($urandom);
            erv0 = 1'b0; erv1 = 1'b0;
            dread_data = 16'($urandom);
            if (rd_q.size() > 0) begin
                e = rd_q.pop_front();
                dread_data = e.data;
                erv0 = ~e.master;
                erv1 = e.master;
            end
            w = predict(m0_req, m1_req);
            ewe = 2'b00; ead = 16'h0; ewd = 16'h0;
            if (w == 0) begin ewe = m0_we; ead = m0_addr; ewd = m0_wdata; end
            if (w == 1) begin ewe = m1_we; ead = m1_addr; ewd = m1_wdata; end
            exp_v = {w == 0, w == 1, ewe, ead, ead, ewd, erv0, erv1, dread_data};
            #1;
            got_v = {m0_gnt, m1_gnt, dwrite_en, dwrite_addr, dread_addr, dwrite_data,
                     m0_rvalid, m1_rvalid, rdata};
            vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL random_c%0d: got %h expected %h", c, got_v, exp_v);
            end
            if (w >= 0 && ewe == 2'b00) rd_q.push_back('{master: w[0], data: 16'($urandom)});
            model_update(w);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        reset_n = 1'b1;
        idle_inputs();
        st = 0; last_w = 1; cnt = 0;
        test_reset();
        test_write();
        test_burst();
        test_back_to_back();
        test_idle_tie();
        test_reset_inflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dbus_arbiter.md
DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 SHALL have parameter MAXBURST, default 4: maximum consecutive grants to one master while the other requests (1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports m0_req / m1_req  input  1  access request, held until granted (m0 = CPU, m1 = DMA).
REQ-005 SHALL have ports m0_addr / m1_addr  input  16  byte address of the access.
REQ-006 SHALL have ports m0_we / m1_we  input  2  byte write enables; 2'b00 = read.
REQ-007 SHALL have ports m0_wdata / m1_wdata  input  16  write data.
REQ-008 SHALL have ports m0_gnt / m1_gnt  output  1  access accepted this cycle.
REQ-009 SHALL have ports m0_rvalid / m1_rvalid  output  1  read data valid for that master.
REQ-010 SHALL have port rdata  output  16  read data, broadcast to both masters.
REQ-011 SHALL have ports dread_addr / dwrite_addr  output  16  shared data-port addresses.
REQ-012 SHALL have port dwrite_data  output  16  shared write data.
REQ-013 SHALL have port dwrite_en  output  2  shared byte write enables.
REQ-014 SHALL have port dread_data  input  16  slave read data, valid one cycle after dread_addr.

Function
REQ-015 SHALL keep registered state: owner state in {IDLE, OWN0, OWN1}, last-winner bit, 4-bit burst count, read tag {valid, master}.
REQ-016 SHALL compute the winner combinationally each cycle; gnt has zero-cycle latency relative to req.
REQ-017 At most one of m0_gnt/m1_gnt SHALL be high in any cycle.
REQ-018 Single requester SHALL win unconditionally.
REQ-019 Both requesting: current owner SHALL keep the bus while count < MAXBURST; otherwise the master that is not the last winner SHALL win.
REQ-020 Both requesting from IDLE: the master that is not the last winner SHALL win.
REQ-021 Count SHALL increment (saturating at 15) on a repeat grant to the same master, load 1 on a grant to a new master, and load 0 in a no-request cycle.
REQ-022 State SHALL become OWNi on a grant to master i and IDLE when there is no request; the last-winner bit SHALL be retained across IDLE.
REQ-023 On a grant, dread_addr, dwrite_addr and dwrite_data SHALL equal the winner's addr and wdata, and dwrite_en SHALL equal the winner's we.
REQ-024 With no grant, dwrite_en SHALL be 2'b00 and the address and data outputs SHALL be 16'h0000.
REQ-025 A granted access with we == 2'b00 SHALL set the read tag; in the next cycle mi_rvalid SHALL be 1 for the tagged master only, with rdata = dread_data.
REQ-026 rdata SHALL equal dread_data every cycle; rvalid SHALL be 0 when no read is tagged.
REQ-027 Back-to-back reads by alternating masters SHALL return data in grant order, one per cycle, with no bubble.
REQ-028 A granted write SHALL produce no rvalid.

Reset
REQ-029 reset_n low SHALL immediately force: state IDLE, last winner = m1 (so m0 wins the first tie), count 0, read tag invalid.
REQ-030 During reset, gnt, rvalid and dwrite_en SHALL be 0.
REQ-031 A read in flight when reset asserts SHALL be discarded, with no rvalid after release.

Structure
REQ-032 Package dbus_pkg SHALL hold the state enum (IDLE/OWN0/OWN1), the master-id typedef and the burst-count width constant.
REQ-033 The request/data multiplexer SHALL be one sub-module, dbus_master_mux (combinational); arbitration and tag state SHALL stay in dbus_arbiter.

Verification
REQ-034 m0 alone writes 16'hBEEF at 16'h2004 with we = 2'b11 -> same cycle: m0_gnt = 1, dwrite_addr = 16'h2004, dwrite_en = 2'b11; no rvalid afterwards.
REQ-035 Both masters request from reset -> m0 granted first; m0 and m1 held continuously with MAXBURST = 4 -> grant pattern 0,0,0,0,1,1,1,1,0.
REQ-036 m1 reads 16'h0010, then m0 reads 16'h2000 in consecutive cycles, with the slave returning 16'h1111 then 16'h2222 -> m1_rvalid with rdata 16'h1111 in cycle 2, then m0_rvalid with rdata 16'h2222 in cycle 3.
REQ-037 m1 granted, one idle cycle, then both request -> m0 wins and count = 1.
REQ-038 m0 read granted, reset_n pulsed low in the following cycle -> m0_rvalid stays 0 and all outputs are at reset values.
REQ-039 Random req/we traffic for 10k cycles -> never two grants, dwrite_en = 0 whenever no grant, and every read yields exactly one rvalid to its issuer.
